// File: rtl/processor_led_pwm_if.sv
// Avalon-MM slave bus for the LED PWM block: register select, write strobe,
// write data and combinational read data.
interface processor_led_pwm_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/processor_led_pwm.sv
// Two-channel LED PWM with prescaled 8-bit counter, shadowed duty registers
// that take effect at the counter wrap, and a global invert.
module processor_led_pwm #(
    parameter int unsigned PRESCALE = 50
) (
    input  logic                 clk,
    input  logic                 reset_n,
    processor_led_pwm_if.slave   bus,
    input  logic [1:0]           led_enable_i,
    output logic [1:0]           led_out_o
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [1:0]  ctrl_q,    ctrl_d;
    logic [7:0]  shadow0_q, shadow0_d;
    logic [7:0]  shadow1_q, shadow1_d;
    logic [7:0]  duty0_q,   duty0_d;
    logic [7:0]  duty1_q,   duty1_d;
    logic [15:0] presc_q,   presc_d;
    logic [7:0]  pwm_cnt_q, pwm_cnt_d;
    logic [1:0]  led_q,     led_d;

    logic        wr_en;
    logic        en;
    logic        inv;
    logic        tick;
    logic        wrap;
    logic [1:0]  raw;
    logic        unused_wdata;

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign en           = ctrl_q[0];
    assign inv          = ctrl_q[1];
    assign tick         = en && (presc_q == PRESC_LAST);
    assign wrap         = tick && (pwm_cnt_q == 8'hFF);
    assign unused_wdata = ^bus.writedata[31:8];

    assign raw[0] = en & led_enable_i[0] & (pwm_cnt_q < duty0_q);
    assign raw[1] = en & led_enable_i[1] & (pwm_cnt_q < duty1_q);

    always_comb begin
        ctrl_d    = ctrl_q;
        shadow0_d = shadow0_q;
        shadow1_d = shadow1_q;
        if (wr_en) begin
            case (bus.address)
                2'd0:    ctrl_d    = bus.writedata[1:0];
                2'd1:    shadow0_d = bus.writedata[7:0];
                2'd2:    shadow1_d = bus.writedata[7:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        presc_d   = presc_q;
        pwm_cnt_d = pwm_cnt_q;
        duty0_d   = duty0_q;
        duty1_d   = duty1_q;
        if (!en) begin
            presc_d   = 16'd0;
            pwm_cnt_d = 8'd0;
            duty0_d   = shadow0_q;
            duty1_d   = shadow1_q;
        end else if (tick) begin
            presc_d   = 16'd0;
            pwm_cnt_d = pwm_cnt_q + 8'd1;
            // Shadows sampled before this edge's bus write, so a write on the
            // wrap cycle waits for the next wrap.
            if (wrap) begin
                duty0_d = shadow0_q;
                duty1_d = shadow1_q;
            end
        end else begin
            presc_d = presc_q + 16'd1;
        end
    end

    assign led_d = raw ^ {2{inv}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q    <= 2'b00;
            shadow0_q <= 8'd0;
            shadow1_q <= 8'd0;
            duty0_q   <= 8'd0;
            duty1_q   <= 8'd0;
            presc_q   <= 16'd0;
            pwm_cnt_q <= 8'd0;
            led_q     <= 2'b00;
        end else begin
            ctrl_q    <= ctrl_d;
            shadow0_q <= shadow0_d;
            shadow1_q <= shadow1_d;
            duty0_q   <= duty0_d;
            duty1_q   <= duty1_d;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
            led_q     <= led_d;
        end
    end

    assign led_out_o = led_q;

    always_comb begin
        bus.readdata = 32'd0;
        case (bus.address)
            2'd0: bus.readdata = {30'd0, ctrl_q};
            2'd1: bus.readdata = {24'd0, shadow0_q};
            2'd2: bus.readdata = {24'd0, shadow1_q};
            2'd3: bus.readdata = {23'd0, en, pwm_cnt_q};
            default: bus.readdata = 32'd0;
        endcase
    end

endmodule
